// File: rtl/ir_frame_pkg.sv
// Shared types and helpers for the pulse-distance IR frame encoder.
package ir_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_BIT,
    ST_STOP,
    ST_GAP
  } state_e;

  // Bit period in clock cycles from a period unit and the clock scale.
  function automatic int unsigned bit_cycles(input int unsigned unit, input int unsigned clk_hz);
    return unit * clk_hz;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Frame is sent LSB first: address, inverted address, code, inverted code.
  function automatic logic [31:0] build_frame(input logic [7:0] addr, input logic [7:0] code);
    return {~code, code, ~addr, addr};
  endfunction

endpackage

// File: rtl/ir_frame_encoder_pulse_timer.sv
// Period timer: level is high for the first `mark` cycles after a load, done on the last cycle.
module pulse_timer #(
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [CW-1:0] period_i,
  input  logic [CW-1:0] mark_i,
  output logic          level_o,
  output logic          done_c
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] period_q;
  logic [CW-1:0] mark_q;
  logic          active_q;
  logic          level_q;
  logic [CW-1:0] count_nxt;

  assign count_nxt = count_q + CW'(1);
  assign done_c    = active_q && (count_nxt == period_q);
  assign level_o   = level_q;

  // A load on the done cycle restarts the count with no gap between periods.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q  <= '0;
      period_q <= '0;
      mark_q   <= '0;
      active_q <= 1'b0;
      level_q  <= 1'b0;
    end else if (load_i) begin
      count_q  <= '0;
      period_q <= period_i;
      mark_q   <= mark_i;
      active_q <= 1'b1;
      level_q  <= (mark_i != '0);
    end else if (done_c) begin
      count_q  <= '0;
      active_q <= 1'b0;
      level_q  <= 1'b0;
    end else if (active_q) begin
      count_q  <= count_nxt;
      level_q  <= (count_nxt < mark_q);
    end
  end

endmodule

// File: rtl/ir_frame_encoder.sv
// Serialises an 8-bit command as a 32-bit pulse-distance frame on a single GPIO line.
module ir_frame_encoder
  import ir_frame_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 250,
  parameter int unsigned BIT_0    = 125,
  parameter int unsigned BIT_1    = 225,
  parameter int unsigned MARK_CYC = (BIT_0 * CLK_HZ) / 2,
  parameter int unsigned LEAD_CYC = 2 * BIT_1 * CLK_HZ,
  parameter int unsigned GAP_CYC  = BIT_1 * CLK_HZ,
  parameter logic [7:0]  ADDR     = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       code_valid,
  input  logic [7:0] code_in,
  output logic       code_ready,
  output logic       gpio,
  output logic       busy
);

  localparam int unsigned N_0 = bit_cycles(BIT_0, CLK_HZ);
  localparam int unsigned N_1 = bit_cycles(BIT_1, CLK_HZ);
  localparam int unsigned CW  = $clog2(max3(N_1, LEAD_CYC, GAP_CYC) + 1);

  if (!(MARK_CYC > 0 && MARK_CYC < N_0)) begin : g_bad_mark
    $fatal(1, "MARK_CYC must satisfy 0 < MARK_CYC < N_0");
  end
  if (!(N_0 < N_1)) begin : g_bad_bits
    $fatal(1, "N_0 must be shorter than N_1");
  end
  if (LEAD_CYC < 2) begin : g_bad_lead
    $fatal(1, "LEAD_CYC must be at least 2");
  end
  if (GAP_CYC < 1) begin : g_bad_gap
    $fatal(1, "GAP_CYC must be at least 1");
  end

  state_e        state_q, state_d;
  logic [31:0]   frame_q, frame_d;
  logic [4:0]    bit_idx_q, bit_idx_d;
  logic [4:0]    bit_idx_nxt;
  logic          code_ready_q, busy_q;
  logic          load_c;
  logic [CW-1:0] period_c, mark_c;
  logic          done_c;

  function automatic logic [CW-1:0] bit_period(input logic b);
    return b ? CW'(N_1) : CW'(N_0);
  endfunction

  assign bit_idx_nxt = bit_idx_q + 5'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      frame_q      <= '0;
      bit_idx_q    <= '0;
      code_ready_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_d;
      bit_idx_q    <= bit_idx_d;
      code_ready_q <= (state_d == ST_IDLE);
      busy_q       <= (state_d != ST_IDLE);
    end
  end

  // Next state and timer load selection; each load lands on the previous period's done cycle.
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bit_idx_d = bit_idx_q;
    load_c    = 1'b0;
    period_c  = '0;
    mark_c    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (code_valid && code_ready_q) begin
          frame_d   = build_frame(ADDR, code_in);
          bit_idx_d = '0;
          load_c    = 1'b1;
          period_c  = CW'(LEAD_CYC);
          mark_c    = CW'(LEAD_CYC / 2);
          state_d   = ST_LEAD;
        end
      end
      ST_LEAD: begin
        if (done_c) begin
          load_c   = 1'b1;
          period_c = bit_period(frame_q[0]);
          mark_c   = CW'(MARK_CYC);
          state_d  = ST_BIT;
        end
      end
      ST_BIT: begin
        if (done_c) begin
          load_c = 1'b1;
          mark_c = CW'(MARK_CYC);
          if (bit_idx_q == 5'd31) begin
            period_c = CW'(MARK_CYC);
            state_d  = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_nxt;
            period_c  = bit_period(frame_q[bit_idx_nxt]);
          end
        end
      end
      ST_STOP: begin
        if (done_c) begin
          load_c   = 1'b1;
          period_c = CW'(GAP_CYC);
          state_d  = ST_GAP;
        end
      end
      ST_GAP: begin
        if (done_c) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  pulse_timer #(
    .CW(CW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (load_c),
    .period_i (period_c),
    .mark_i   (mark_c),
    .level_o  (gpio),
    .done_c   (done_c)
  );

  assign code_ready = code_ready_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_ir_frame_encoder.sv
// Self-checking bench for ir_frame_encoder using a segment-based waveform model and a loopback decoder.
module tb_ir_frame_encoder;

  localparam int N0   = 4;
  localparam int N1   = 8;
  localparam int MARK = 2;
  localparam int LEAD = 16;
  localparam int GAP  = 8;
  localparam logic [7:0] ADDR_V = 8'h00;

  logic       clk;
  logic       rst_n;
  logic       code_valid;
  logic [7:0] code_in;
  logic       code_ready;
  logic       gpio;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  bit exp_q[$];
  bit obs_q[$];

  typedef struct {
    logic [7:0] code;
    int         exp_len;
    int         exp_edges;
    logic [7:0] exp_dec;
  } vec_t;

  vec_t vt[5];

  ir_frame_encoder #(
    .CLK_HZ   (1),
    .BIT_0    (N0),
    .BIT_1    (N1),
    .MARK_CYC (MARK),
    .LEAD_CYC (LEAD),
    .GAP_CYC  (GAP),
    .ADDR     (ADDR_V)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .code_valid (code_valid),
    .code_in    (code_in),
    .code_ready (code_ready),
    .gpio       (gpio),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected line level per cycle, built from the frame's segment list.
  task automatic model_wave(input logic [7:0] code);
    logic [31:0] frame;
    int p;
    frame = {~code, code, ~ADDR_V, ADDR_V};
    exp_q.delete();
    for (int k = 0; k < LEAD; k++) exp_q.push_back(k < LEAD / 2);
    for (int i = 0; i < 32; i++) begin
      p = frame[i] ? N1 : N0;
      for (int k = 0; k < p; k++) exp_q.push_back(k < MARK);
    end
    for (int k = 0; k < MARK; k++) exp_q.push_back(1'b1);
    for (int k = 0; k < GAP; k++) exp_q.push_back(1'b0);
  endtask

  // Reference pulse-distance decoder applied to the captured line.
  task automatic decode(output int edges, output logic [7:0] dec);
    int e[$];
    logic [31:0] bits;
    for (int k = 0; k < obs_q.size(); k++)
      if (obs_q[k] && (k == 0 || !obs_q[k-1])) e.push_back(k);
    edges = e.size();
    bits = '0;
    for (int i = 0; i < 32; i++)
      if (i + 2 < e.size()) bits[i] = (e[i+2] - e[i+1]) > ((N0 + N1) / 2);
    dec = bits[23:16];
  endtask

  // mode 0: drop valid after accept; 1: random valid/code noise while busy; 2: valid held, code churning.
  task automatic run_frame(input logic [7:0] code, input int mode, output int start_cyc,
                           output int len, output int edges, output logic [7:0] dec);
    int w, k, busy_bad, mism, n;
    w = 0;
    while (code_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("ready_before_send", 32'(code_ready), 32'd1);
    code_in    = code;
    code_valid = 1'b1;
    @(negedge clk);
    start_cyc = cyc;
    obs_q.delete();
    busy_bad = 0;
    k = 0;
    while (code_ready !== 1'b0 ? 1'b0 : 1'b1) begin
      if (k >= 1000) break;
      obs_q.push_back(gpio);
      if (busy !== 1'b1) busy_bad++;
      case (mode)
        0: code_valid = 1'b0;
        1: begin
          code_valid = 1'($urandom_range(0, 1));
          code_in    = 8'($urandom);
        end
        default: code_in = 8'($urandom);
      endcase
      @(negedge clk);
      k++;
    end
    if (mode == 1) code_valid = 1'b0;
    check("frame_bounded", 32'(k < 1000), 32'd1);
    check("busy_during_frame", 32'(busy_bad), 32'd0);
    check("busy_after_gap", 32'(busy), 32'd0);
    check("gpio_after_gap", 32'(gpio), 32'd0);
    model_wave(code);
    n = (exp_q.size() > obs_q.size()) ? exp_q.size() : obs_q.size();
    mism = 0;
    for (int j = 0; j < n; j++)
      if (j >= obs_q.size() || j >= exp_q.size() || obs_q[j] != exp_q[j]) mism++;
    check("waveform_cycles_wrong", 32'(mism), 32'd0);
    len = obs_q.size();
    decode(edges, dec);
  endtask

  initial begin
    int st, len, edges, st_prev, t;
    logic [7:0] dec, c;
    logic [31:0] fr;

    vt[0] = '{8'h01, 218, 34, 8'h01};
    vt[1] = '{8'h00, 218, 34, 8'h00};
    vt[2] = '{8'hA5, 218, 34, 8'hA5};
    vt[3] = '{8'hFF, 218, 34, 8'hFF};
    vt[4] = '{8'h3C, 218, 34, 8'h3C};

    rst_n      = 1'b0;
    code_valid = 1'b0;
    code_in    = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_gpio", 32'(gpio), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(code_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(code_ready), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_gpio", 32'(gpio), 32'd0);

    // Table-driven frames
    for (int i = 0; i < 5; i++) begin
      run_frame(vt[i].code, 0, st, len, edges, dec);
      check("vec_len", 32'(len), 32'(vt[i].exp_len));
      check("vec_edges", 32'(edges), 32'(vt[i].exp_edges));
      check("vec_decoded", 32'(dec), 32'(vt[i].exp_dec));
    end

    // Valid held high: back-to-back accepts with the code sampled at each accept edge
    st_prev = -1;
    for (int i = 0; i < 3; i++) begin
      c = (i == 0) ? 8'h01 : 8'($urandom);
      run_frame(c, 2, st, len, edges, dec);
      check("hold_decoded", 32'(dec), 32'(c));
      if (st_prev >= 0) check("hold_spacing", 32'(st - st_prev), 32'd219);
      st_prev = st;
    end
    code_valid = 1'b0;

    // Valid pulses while busy must not disturb the frame
    run_frame(8'hC3, 1, st, len, edges, dec);
    check("noise_decoded", 32'(dec), 32'hC3);
    check("noise_edges", 32'(edges), 32'd34);
    @(negedge clk);
    check("noise_no_extra_accept", 32'(busy), 32'd0);

    // Reset during bit 12
    fr = {~8'h5A, 8'h5A, ~ADDR_V, ADDR_V};
    t = LEAD;
    for (int i = 0; i < 12; i++) t += fr[i] ? N1 : N0;
    code_in    = 8'h5A;
    code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
    repeat (t + 1) @(negedge clk);
    check("bit12_mark_high", 32'(gpio), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_gpio", 32'(gpio), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(code_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready_after", 32'(code_ready), 32'd1);
    run_frame(8'h5A, 0, st, len, edges, dec);
    check("after_abort_decoded", 32'(dec), 32'h5A);
    check("after_abort_len", 32'(len), 32'd218);

    // Random codes against the model
    for (int i = 0; i < 6; i++) begin
      c = 8'($urandom);
      run_frame(c, int'($urandom_range(0, 1)), st, len, edges, dec);
      check("rand_decoded", 32'(dec), 32'(c));
      check("rand_edges", 32'(edges), 32'd34);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
